// File: rtl/mem_access_unit_if.sv
// Handshake and memory-side bundle for mem_access_unit.
// The master side is the requester plus the memory; the slave side is the unit itself.
interface mem_access_unit_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
);
  logic                  req;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [2:0]            len;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  busy;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  done;
  logic                  err;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_write;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output req, we, addr_in, len, wdata, mem_rdata,
    input  busy, rdata, rvalid, done, err, mem_addr, mem_wdata, mem_write
  );

  modport slave (
    input  req, we, addr_in, len, wdata, mem_rdata,
    output busy, rdata, rvalid, done, err, mem_addr, mem_wdata, mem_write
  );
endinterface

// File: rtl/mem_access_unit.sv
// Sequences single-word writes and 1..4 word burst reads onto a simple memory port
// (SETUP / ACCESS / HOLD per beat) with a range check at acceptance. All outputs registered.
module mem_access_unit #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int MEM_SIZE    = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic               clk,
  input logic               rst_n,
  mem_access_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_ACCESS, S_HOLD, S_FINISH, S_ERROR
  } state_t;

  localparam logic [3:0]          WAIT_LOAD = 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_SIZE);

  state_t state_q, state_d;
  logic   we_q, we_d;
  logic [2:0] beats_q, beats_d;
  logic [3:0] wait_q, wait_d;

  logic [2:0]            len_eff;
  logic [ADDR_WIDTH:0]   last_addr;
  logic                  range_err;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  rvalid_q, rvalid_d;
  logic                  mem_write_q, mem_write_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;

  // Last word touched, one bit wider than the address so a wrap cannot hide an overrun.
  always_comb begin
    len_eff   = (bus.we || bus.len == 3'd0) ? 3'd1 : bus.len;
    last_addr = {1'b0, bus.addr_in} + (ADDR_WIDTH+1)'(len_eff) - (ADDR_WIDTH+1)'(1);
    range_err = last_addr >= MEM_LIMIT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      beats_q     <= '0;
      wait_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rvalid_q    <= 1'b0;
      mem_write_q <= 1'b0;
      rdata_q     <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      beats_q     <= beats_d;
      wait_q      <= wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rvalid_q    <= rvalid_d;
      mem_write_q <= mem_write_d;
      rdata_q     <= rdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    beats_d = beats_q;
    wait_d  = wait_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          beats_d = len_eff;
          state_d = range_err ? S_ERROR : S_SETUP;
        end
      end
      S_SETUP: begin
        wait_d  = WAIT_LOAD;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        if (wait_q == 4'd0) state_d = S_HOLD;
        else                wait_d  = wait_q - 4'd1;
      end
      S_HOLD: begin
        if (beats_q > 3'd1) begin
          beats_d = beats_q - 3'd1;
          state_d = S_SETUP;
        end else begin
          state_d = S_FINISH;
        end
      end
      S_FINISH, S_ERROR: state_d = S_IDLE;
      default:           state_d = S_IDLE;
    endcase
  end

  // Outputs are the registered image of the state being entered.
  always_comb begin
    busy_d      = state_d != S_IDLE;
    done_d      = state_d == S_FINISH || state_d == S_ERROR;
    err_d       = state_d == S_ERROR;
    mem_write_d = state_d == S_ACCESS && we_d;
    rvalid_d    = state_q == S_ACCESS && state_d == S_HOLD && !we_d;
    rdata_d     = rvalid_d ? bus.mem_rdata : rdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if (state_q == S_IDLE && bus.req) begin
      mem_addr_d  = bus.addr_in;
      mem_wdata_d = bus.wdata;
    end else if (state_q == S_HOLD && state_d == S_SETUP) begin
      // Address steps only on HOLD->SETUP, where mem_write is already low.
      mem_addr_d = mem_addr_q + 1'b1;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: transaction-level model predicts every output per cycle,
// plus directed literal checks on latency, pulses and captured data.
module tb_mem_access_unit;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MEM_SIZE = 1024;
  localparam int WAIT = 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mem_access_unit_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_access_unit #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_SIZE(MEM_SIZE), .WAIT_CYCLES(WAIT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  // Memory attached to the unit
  logic [DW-1:0] env_mem [MEM_SIZE] = '{default: '0};
  assign bus.mem_rdata = (int'(bus.mem_addr) < MEM_SIZE) ? env_mem[bus.mem_addr[9:0]] : '0;
  always @(posedge clk)
    if (bus.mem_write && int'(bus.mem_addr) < MEM_SIZE) env_mem[bus.mem_addr[9:0]] <= bus.mem_wdata;

  typedef struct {
    bit busy, done, err, rvalid, mem_write;
    int rdata, mem_addr, mem_wdata;
  } exp_t;

  exp_t exp_q[$];
  int   model_mem [MEM_SIZE] = '{default: 0};
  int   m_rdata, m_mem_addr, m_mem_wdata;
  int   n_cmp, n_fail, cyc;
  int   t0, done_lat, done_count, err_count, wr_cycles, wr_addr;
  int   rv_q[$];
  int   rva_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(bit b, bit dn, bit er, bit rv, bit wr);
    exp_t e;
    e.busy = b; e.done = dn; e.err = er; e.rvalid = rv; e.mem_write = wr;
    e.rdata = m_rdata; e.mem_addr = m_mem_addr; e.mem_wdata = m_mem_wdata;
    return e;
  endfunction

  // Expected per-cycle trace: the IDLE cycle in which req is sampled, then
  // SETUP, WAIT access cycles, HOLD per beat, then a done cycle.
  task automatic push_txn(bit w, int a, int l, int d);
    int n = (w || l == 0) ? 1 : l;
    exp_q.push_back(mk(0, 0, 0, 0, 0));
    m_mem_addr  = a;
    m_mem_wdata = d;
    if (a + n - 1 >= MEM_SIZE) begin
      exp_q.push_back(mk(1, 1, 1, 0, 0));
      return;
    end
    for (int b = 0; b < n; b++) begin
      m_mem_addr = a + b;
      exp_q.push_back(mk(1, 0, 0, 0, 0));
      for (int k = 0; k < WAIT; k++) exp_q.push_back(mk(1, 0, 0, 0, w));
      if (!w) m_rdata = model_mem[a + b];
      exp_q.push_back(mk(1, 0, 0, !w, 0));
    end
    if (w) model_mem[a] = d;
    exp_q.push_back(mk(1, 1, 0, 0, 0));
  endtask

  // Compare process and event monitor
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else                  e = mk(0, 0, 0, 0, 0);
    check("busy",      bus.busy,      32'(e.busy));
    check("done",      bus.done,      32'(e.done));
    check("err",       bus.err,       32'(e.err));
    check("rvalid",    bus.rvalid,    32'(e.rvalid));
    check("mem_write", bus.mem_write, 32'(e.mem_write));
    check("rdata",     bus.rdata,     e.rdata);
    check("mem_addr",  bus.mem_addr,  e.mem_addr);
    check("mem_wdata", bus.mem_wdata, e.mem_wdata);
    if (bus.done) begin done_count++; done_lat = cyc - t0 + 1; end
    if (bus.err) err_count++;
    if (bus.mem_write) begin wr_cycles++; wr_addr = int'(bus.mem_addr); end
    if (bus.rvalid) begin rv_q.push_back(int'(bus.rdata)); rva_q.push_back(int'(bus.mem_addr)); end
  end

  task automatic clear_mon();
    done_count = 0; err_count = 0; wr_cycles = 0; wr_addr = -1; done_lat = -1;
    rv_q.delete(); rva_q.delete();
  endtask

  task automatic start_txn(bit w, int a, int l, int d);
    @(posedge clk); #1;
    bus.we = w; bus.addr_in = AW'(a); bus.len = 3'(l); bus.wdata = DW'(d); bus.req = 1'b1;
    push_txn(w, a, l, d);
    clear_mon();
    @(posedge clk); #1;
    t0 = cyc;
    bus.req = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() > 0 && k < 200) begin @(negedge clk); #1; k++; end
    if (exp_q.size() > 0) begin
      check("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved, s1, l2, k;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr_in = '0; bus.len = '0; bus.wdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_mem_write", bus.mem_write, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_rdata", bus.rdata, 0);
    rst_n = 1'b1;

    // Single write
    start_txn(1, 5, 0, 'h2bcd); drain();
    check("wr5_done_lat", done_lat, 4);
    check("wr5_wr_cycles", wr_cycles, 1);
    check("wr5_wr_addr", wr_addr, 5);
    check("wr5_err", err_count, 0);

    // Burst read of {0x2bcd, 0, 0}
    start_txn(1, 0, 0, 'h2bcd); drain();
    start_txn(0, 0, 3, 0); drain();
    check("rd0_beats", rv_q.size(), 3);
    if (rv_q.size() == 3) begin
      check("rd0_data0", rv_q[0], 'h2bcd);
      check("rd0_data1", rv_q[1], 0);
      check("rd0_data2", rv_q[2], 0);
      check("rd0_addr2", rva_q[2], 2);
    end
    check("rd0_done_lat", done_lat, 10);
    check("rd0_wr_cycles", wr_cycles, 0);

    // Out-of-range read
    start_txn(0, 1022, 4, 0); drain();
    check("rd1022_err", err_count, 1);
    check("rd1022_done", done_count, 1);
    check("rd1022_rvalid", rv_q.size(), 0);
    check("rd1022_wr", wr_cycles, 0);
    check("rd1022_lat", done_lat, 1);

    // Write boundaries
    start_txn(1, 1023, 0, 'h1111); drain();
    check("wr1023_err", err_count, 0);
    check("wr1023_done", done_count, 1);
    check("wr1023_addr", wr_addr, 1023);
    start_txn(1, 1024, 0, 'h2222); drain();
    check("wr1024_err", err_count, 1);
    check("wr1024_wr", wr_cycles, 0);

    // len=0 read is a single beat; full-range burst ending at the last word
    start_txn(0, 5, 0, 0); drain();
    check("rdlen0_beats", rv_q.size(), 1);
    if (rv_q.size() == 1) check("rdlen0_data", rv_q[0], 'h2bcd);
    check("rdlen0_lat", done_lat, 4);
    start_txn(0, 1020, 4, 0); drain();
    check("rd1020_beats", rv_q.size(), 4);
    if (rv_q.size() == 4) check("rd1020_last", rv_q[3], 'h1111);
    check("rd1020_lat", done_lat, 13);
    check("rd1020_err", err_count, 0);

    // req pulsed while busy is dropped
    start_txn(1, 7, 0, 'h00a5);
    @(posedge clk); #1;
    bus.req = 1'b1; bus.we = 1'b0; bus.addr_in = AW'(100); bus.len = 3'd2;
    @(posedge clk); #1;
    bus.req = 1'b0;
    drain();
    check("pulse_done_count", done_count, 1);

    // req held: two back-to-back transactions with one IDLE cycle between
    @(posedge clk); #1;
    bus.we = 1'b1; bus.addr_in = AW'(20); bus.len = 3'd0; bus.wdata = DW'('h0bee); bus.req = 1'b1;
    push_txn(1, 20, 0, 'h0bee);
    s1 = exp_q.size();
    push_txn(0, 20, 2, 0);
    l2 = exp_q.size() - s1;
    clear_mon();
    @(posedge clk); #1;
    bus.we = 1'b0; bus.addr_in = AW'(20); bus.len = 3'd2; bus.wdata = '0;
    k = 0;
    while (exp_q.size() > l2 - 1 && k < 200) begin @(negedge clk); #1; k++; end
    @(posedge clk); #1;
    bus.req = 1'b0;
    drain();
    check("held_done_count", done_count, 2);
    check("held_beats", rv_q.size(), 2);
    if (rv_q.size() == 2) check("held_data0", rv_q[0], 'h0bee);

    // Reset during the ACCESS cycle of a write
    saved = model_mem[9];
    start_txn(1, 9, 0, 'h7777);
    @(posedge clk); #1;
    check("rst_pre_wr", bus.mem_write, 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_wr", bus.mem_write, 0);
    check("rst_async_busy", bus.busy, 0);
    check("rst_async_addr", bus.mem_addr, 0);
    exp_q.delete();
    m_rdata = 0; m_mem_addr = 0; m_mem_wdata = 0;
    model_mem[9] = saved;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_no_done", done_count, 0);

    start_txn(1, 9, 0, 'h3333); drain();
    check("post_rst_lat", done_lat, 4);
    start_txn(0, 9, 1, 0); drain();
    check("post_rst_beats", rv_q.size(), 1);
    if (rv_q.size() == 1) check("post_rst_data", rv_q[0], 'h3333);

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
